// File: rtl/sign_ext_arbiter_pkg.sv
// Shared definitions for the immediate extender arbiter: ctrl encodings and widths.
package sign_ext_pkg;

    localparam int IMM_W  = 26;
    localparam int DATA_W = 64;
    localparam int CTRL_W = 3;

    typedef enum logic [CTRL_W-1:0] {
        EXT_D   = 3'b000,
        EXT_IR  = 3'b001,
        EXT_B   = 3'b010,
        EXT_CB  = 3'b011,
        EXT_MOV = 3'b111
    } ext_ctrl_e;

endpackage

// File: rtl/sign_ext_arbiter_if.sv
// Request, result and counter bundle between the two requesters, the consumer and the arbiter.
interface sign_ext_arbiter_if #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    import sign_ext_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [IMM_W-1:0]  req0_imm;
    logic [CTRL_W-1:0] req0_ctrl;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid;
    logic              req1_ready;
    logic [IMM_W-1:0]  req1_imm;
    logic [CTRL_W-1:0] req1_ctrl;
    logic [TAG_W-1:0]  req1_tag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic              out_src;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    logic [CNT_W-1:0]  grant_cnt0;
    logic [CNT_W-1:0]  grant_cnt1;

    modport slave (
        input  req0_valid, req0_imm, req0_ctrl, req0_tag,
        input  req1_valid, req1_imm, req1_ctrl, req1_tag,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_imm, out_src, out_tag, out_err,
        output grant_cnt0, grant_cnt1
    );

    modport master (
        output req0_valid, req0_imm, req0_ctrl, req0_tag,
        output req1_valid, req1_imm, req1_ctrl, req1_tag,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_imm, out_src, out_tag, out_err,
        input  grant_cnt0, grant_cnt1
    );

endinterface

// File: rtl/sign_ext_arbiter_core.sv
// Combinational 26-bit immediate field to 64-bit operand extender; flags unknown ctrl codes.
// Zero latency, no state, no handshake.
module sign_ext_core
    import sign_ext_pkg::*;
(
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [DATA_W-1:0] imm64_o,
    output logic              illegal_o
);

    always_comb begin
        imm64_o   = '0;
        illegal_o = 1'b0;
        case (ctrl_i)
            EXT_D:   imm64_o = {{55{imm_i[20]}}, imm_i[20:12]};
            EXT_IR:  imm64_o = {{52{imm_i[21]}}, imm_i[21:10]};
            EXT_B:   imm64_o = {{38{imm_i[25]}}, imm_i[25:0]};
            EXT_CB:  imm64_o = {{45{imm_i[23]}}, imm_i[23:5]};
            // 16-bit chunk placed in one of four halfword lanes
            EXT_MOV: imm64_o = DATA_W'(imm_i[20:5]) << {imm_i[22:21], 4'b0000};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/sign_ext_arbiter.sv
// Round-robin share of one immediate extender between decode (0) and branch-target (1); result 1 cycle after accept.
// Backpressure: both readies drop while a result is stalled; a draining slot accepts a new request the same cycle.
// Optional SIGN_EXT_ERR_EN: illegal ctrl codes raise out_err alongside the zero result.
module sign_ext_arbiter
    import sign_ext_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic CLK,
    input  logic RST_N,
    sign_ext_arbiter_if.slave bus
);

`ifdef SIGN_EXT_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic              accept, sel, grant_vld;
    logic [IMM_W-1:0]  mux_imm;
    logic [CTRL_W-1:0] mux_ctrl;
    logic [TAG_W-1:0]  mux_tag;
    logic [DATA_W-1:0] ext_imm;
    logic              ext_ill;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d;
    logic              out_src_q, out_src_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_err_q, out_err_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        accept    = !out_valid_q || bus.out_ready;
        // under contention the requester that did not win last time goes first
        sel       = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
        grant_vld = accept && (bus.req0_valid || bus.req1_valid);
        mux_imm   = sel ? bus.req1_imm  : bus.req0_imm;
        mux_ctrl  = sel ? bus.req1_ctrl : bus.req0_ctrl;
        mux_tag   = sel ? bus.req1_tag  : bus.req0_tag;
    end

    sign_ext_core u_core (
        .imm_i     (mux_imm),
        .ctrl_i    (mux_ctrl),
        .imm64_o   (ext_imm),
        .illegal_o (ext_ill)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_src_d    = out_src_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (grant_vld) begin
            out_valid_d  = 1'b1;
            out_imm_d    = ext_imm;
            out_src_d    = sel;
            out_tag_d    = mux_tag;
            out_err_d    = ext_ill & ERR_EN;
            last_grant_d = sel;
            if (sel) cnt1_d = cnt1_q + CNT_W'(1);
            else     cnt0_d = cnt0_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_src_q    <= 1'b0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_src_q    <= out_src_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.req0_ready = grant_vld && !sel;
    assign bus.req1_ready = grant_vld && sel;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_imm    = out_imm_q;
    assign bus.out_src    = out_src_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_err    = out_err_q;
    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;

endmodule
